// File: rtl/regfile_wb_arbiter_pkg.sv
// proc_pkg: constants shared across the processor slice.
//  - register file geometry (DATA_W, ADDR_W, NUM_REGS)
//  - default writeback-arbiter sizing (N_REQ_DEF, CNT_W_DEF)
//  - stack-pointer register index
//  - writeback requester indices (fixed priority order, 0 = highest)
//  - CCR bit positions within the {V,C,N,Z} flag nibble
package proc_pkg;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 2;
  localparam int NUM_REGS  = 4;

  localparam int N_REQ_DEF = 4;
  localparam int CNT_W_DEF = 2;

  localparam int SP_IDX    = 3;

  typedef enum logic [1:0] {
    REQ_ALU    = 2'd0,
    REQ_MEM    = 2'd1,
    REQ_INPORT = 2'd2,
    REQ_SP     = 2'd3
  } req_id_e;

  localparam int CCR_Z = 0;
  localparam int CCR_N = 1;
  localparam int CCR_C = 2;
  localparam int CCR_V = 3;

endpackage

// File: rtl/regfile_wb_arbiter_grant.sv
// wb_grant_picker: one-hot grant over a request vector.
//  Macro REGFILE_ARB_RR_EN selects round-robin (search starts at i_ptr);
//  otherwise fixed priority, lowest index wins, and i_ptr is ignored.
// Ports:
//  i_req   [N_REQ]  requests (already masked by hold/reset)
//  i_ptr   [PTR_W]  round-robin start index
//  o_grant [N_REQ]  one-hot grant, zero when no request
module wb_grant_picker
  import proc_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant
);

  logic w_found;

`ifdef REGFILE_ARB_RR_EN
  logic [PTR_W-1:0] w_idx;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_idx = PTR_W'((int'(i_ptr) + k) % N_REQ);
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end
`else
  logic w_unused_ptr;
  assign w_unused_ptr = ^i_ptr;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!w_found && i_req[k]) begin
        o_grant[k] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port among the writeback
// requesters (ALU, memory load, IN port, SP update), one grant per cycle,
// registered onto the port. Also keeps a per-register pending-write
// scoreboard used by decode for RAW stalls.
// Configuration macro: REGFILE_ARB_RR_EN (round-robin; default fixed priority).
// Ports:
//  clk, rst                 clock, async active-high reset
//  req_valid/req_ready      per-requester handshake (ready is one-hot, comb)
//  req_addr/data/flags_en/flags  packed per-requester payload
//  wr_hold                  freeze: no grant while high
//  wr_en/addr/data          registered register-file write port
//  flags_en/flags           registered CCR write port
//  sb_alloc/sb_alloc_addr   decode allocation of a future write
//  sb_alloc_ok              target counter not saturated
//  sb_busy                  per-register pending-write indication
module regfile_wb_arbiter
  import proc_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int DATA_W   = proc_pkg::DATA_W,
  parameter int ADDR_W   = proc_pkg::ADDR_W,
  parameter int NUM_REGS = proc_pkg::NUM_REGS,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]      req_flags_en,
  input  logic [N_REQ*4-1:0]    req_flags,
  input  logic                  wr_hold,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic                  flags_en,
  output logic [3:0]            flags,
  input  logic                  sb_alloc,
  input  logic [ADDR_W-1:0]     sb_alloc_addr,
  output logic                  sb_alloc_ok,
  output logic [NUM_REGS-1:0]   sb_busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // ---------------- arbitration ----------------
  logic [N_REQ-1:0]  w_req_eff;
  logic [N_REQ-1:0]  w_grant;
  logic [PTR_W-1:0]  w_ptr;
  logic              w_any;

  // Reset and hold both suppress every grant combinationally.
  assign w_req_eff = (rst || wr_hold) ? '0 : req_valid;
  assign w_any     = |w_grant;
  assign req_ready = w_grant;

  wb_grant_picker #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .i_req   (w_req_eff),
    .i_ptr   (w_ptr),
    .o_grant (w_grant)
  );

  // Winner payload mux (grant is one-hot, so a priority loop is a plain select).
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_sel_fen;
  logic [3:0]        w_sel_flags;

  always_comb begin
    w_sel_addr  = '0;
    w_sel_data  = '0;
    w_sel_fen   = 1'b0;
    w_sel_flags = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        w_sel_data  = req_data[i*DATA_W +: DATA_W];
        w_sel_fen   = req_flags_en[i];
        w_sel_flags = req_flags[i*4 +: 4];
      end
    end
  end

`ifdef REGFILE_ARB_RR_EN
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_win_idx;

  always_comb begin
    w_win_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) w_win_idx = PTR_W'(i);
    end
  end

  // Pointer moves past the winner only when a grant actually happened.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= PTR_W'((int'(w_win_idx) + 1) % N_REQ);
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  // ---------------- write port registers ----------------
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_flags_en;
  logic [3:0]        r_flags;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_flags_en <= 1'b0;
      r_flags    <= '0;
    end else begin
      r_wr_en    <= w_any;
      r_flags_en <= w_any & w_sel_fen;
      if (w_any) begin
        r_wr_addr <= w_sel_addr;
        r_wr_data <= w_sel_data;
      end
      if (w_any && w_sel_fen) begin
        r_flags <= w_sel_flags;
      end
    end
  end

  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign flags_en = r_flags_en;
  assign flags    = r_flags;

  // ---------------- scoreboard ----------------
  logic [CNT_W-1:0]    r_cnt     [NUM_REGS];
  logic [CNT_W-1:0]    w_cnt_nxt [NUM_REGS];
  logic [NUM_REGS-1:0] w_inc;
  logic [NUM_REGS-1:0] w_dec;
  logic                w_alloc_fire;

  assign sb_alloc_ok  = (r_cnt[sb_alloc_addr] != '1);
  assign w_alloc_fire = sb_alloc & sb_alloc_ok;

  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      w_inc[r]     = w_alloc_fire && (sb_alloc_addr == ADDR_W'(r));
      w_dec[r]     = r_wr_en && (r_wr_addr == ADDR_W'(r));
      w_cnt_nxt[r] = r_cnt[r];
      // Alloc and commit to the same register cancel; decrement saturates at 0.
      if (w_inc[r] && !w_dec[r]) begin
        w_cnt_nxt[r] = r_cnt[r] + CNT_W'(1);
      end else if (w_dec[r] && !w_inc[r] && (r_cnt[r] != '0)) begin
        w_cnt_nxt[r] = r_cnt[r] - CNT_W'(1);
      end
      sb_busy[r] = (r_cnt[r] != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        r_cnt[r] <= '0;
      end
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [7:0]  req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_flags_en;
  logic [15:0] req_flags;
  logic        wr_hold;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        flags_en;
  logic [3:0]  flags;
  logic        sb_alloc;
  logic [1:0]  sb_alloc_addr;
  logic        sb_alloc_ok;
  logic [3:0]  sb_busy;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .N_REQ    (4),
    .DATA_W   (8),
    .ADDR_W   (2),
    .NUM_REGS (4),
    .CNT_W    (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_flags_en  (req_flags_en),
    .req_flags     (req_flags),
    .wr_hold       (wr_hold),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .flags_en      (flags_en),
    .flags         (flags),
    .sb_alloc      (sb_alloc),
    .sb_alloc_addr (sb_alloc_addr),
    .sb_alloc_ok   (sb_alloc_ok),
    .sb_busy       (sb_busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int         m_ptr = 0;
  logic       m_wr_en = 1'b0;
  logic       m_flags_en = 1'b0;
  logic [1:0] m_addr = '0;
  logic [7:0] m_data = '0;
  logic [3:0] m_flags = '0;
  logic [3:0] m_last_grant = '0;
  int         m_cnt [4] = '{0, 0, 0, 0};
  localparam int CNT_MAX = 3;

  function automatic logic [3:0] model_grant();
    int i;
    if (rst === 1'b1 || wr_hold) return 4'b0000;
    for (int k = 0; k < 4; k++) begin
`ifdef REGFILE_ARB_RR_EN
      i = (m_ptr + k) % 4;
`else
      i = k;
`endif
      if (req_valid[i]) return 4'(1 << i);
    end
    return 4'b0000;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_wr_en = 0; m_flags_en = 0; m_addr = 0; m_data = 0; m_flags = 0;
    m_last_grant = 0;
    for (int r = 0; r < 4; r++) m_cnt[r] = 0;
  endtask

  task automatic model_step();
    logic [3:0] g;
    int  w;
    bit  alloc;
    g     = model_grant();
    alloc = sb_alloc && (m_cnt[sb_alloc_addr] != CNT_MAX);
    if (!(alloc && m_wr_en && (m_addr == sb_alloc_addr))) begin
      if (alloc) m_cnt[sb_alloc_addr]++;
      if (m_wr_en && m_cnt[m_addr] > 0) m_cnt[m_addr]--;
    end
    if (g != 0) begin
      w = 0;
      for (int i = 0; i < 4; i++) if (g[i]) w = i;
      m_wr_en    = 1;
      m_addr     = req_addr[w*2 +: 2];
      m_data     = req_data[w*8 +: 8];
      m_flags_en = req_flags_en[w];
      if (req_flags_en[w]) m_flags = req_flags[w*4 +: 4];
`ifdef REGFILE_ARB_RR_EN
      m_ptr = (w + 1) % 4;
`endif
    end else begin
      m_wr_en    = 0;
      m_flags_en = 0;
    end
    m_last_grant = g;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) model_reset();
    else     model_step();
  end

  // Compare process: every cycle, away from the clock edge.
  initial forever begin
    logic [3:0] busy;
    @(negedge clk);
    #2;
    for (int r = 0; r < 4; r++) busy[r] = (m_cnt[r] != 0);
    chk("ready",    req_ready,   model_grant());
    chk("wr_en",    wr_en,       m_wr_en);
    chk("wr_addr",  wr_addr,     m_addr);
    chk("wr_data",  wr_data,     m_data);
    chk("flags_en", flags_en,    m_flags_en);
    chk("flags",    flags,       m_flags);
    chk("sb_busy",  sb_busy,     busy);
    chk("alloc_ok", sb_alloc_ok, m_cnt[sb_alloc_addr] != CNT_MAX);
  end

  // ---------------- stimulus ----------------
  task automatic clr_inputs();
    req_valid = '0; req_addr = '0; req_data = '0; req_flags_en = '0; req_flags = '0;
    wr_hold = 0; sb_alloc = 0; sb_alloc_addr = 0;
  endtask

  task automatic drive_req(input int i, input int a, input int d, input bit fe, input int f);
    req_addr[i*2 +: 2]  = 2'(a);
    req_data[i*8 +: 8]  = 8'(d);
    req_flags_en[i]     = fe;
    req_flags[i*4 +: 4] = 4'(f);
  endtask

`ifdef REGFILE_ARB_RR_EN
  logic [3:0] exp3 [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
  logic [3:0] exp3 [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif

  initial begin
    clr_inputs();
    repeat (2) @(negedge clk);
    #2 chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", sb_busy, 0);
    rst = 0;

    // single ALU request
    @(negedge clk);
    drive_req(0, 2, 8'hA5, 1, 4'b0010); req_valid = 4'b0001;
    #2 chk("t2_ready", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = 0;
    #2 chk("t2_wr_en", wr_en, 1);
    chk("t2_wr_addr", wr_addr, 2);
    chk("t2_wr_data", wr_data, 8'hA5);
    chk("t2_flags_en", flags_en, 1);
    chk("t2_flags", flags, 4'b0010);
    @(negedge clk);
    #2 chk("t2_wr_en_drop", wr_en, 0);
    chk("t2_data_kept", wr_data, 8'hA5);

    // reset mid-grant
    @(negedge clk);
    drive_req(0, 1, 8'h3C, 1, 4'b1001); req_valid = 4'b0001;
    #2 chk("t1_ready", req_ready, 4'b0001);
    @(negedge clk);
    #1 chk("t1_wr_en_pre", wr_en, 1);
    rst = 1;
    #1 chk("t1_wr_en", wr_en, 0);
    chk("t1_wr_data", wr_data, 0);
    chk("t1_flags", flags, 0);
    chk("t1_ready", req_ready, 0);
    @(negedge clk);
    rst = 0; req_valid = 0;
    #2 chk("t1_no_write", wr_en, 0);
    @(negedge clk);
    #2 chk("t1_no_write2", wr_en, 0);

    // all four valid, held
    @(negedge clk);
    for (int i = 0; i < 4; i++) drive_req(i, i, 8'h10 + i, 0, 0);
    req_valid = 4'hF;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      #2 chk($sformatf("t3_grant%0d", c), req_ready, exp3[c]);
    end
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);

    // hold
    wr_hold = 1; drive_req(1, 0, 8'h77, 0, 0); req_valid = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #2 chk("t4_ready_held", req_ready, 0);
      chk("t4_wr_en_held", wr_en, 0);
    end
    @(negedge clk);
    wr_hold = 0;
    #2 chk("t4_ready_rel", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = 0;
    #2 chk("t4_wr_en", wr_en, 1);
    chk("t4_wr_data", wr_data, 8'h77);

    // scoreboard saturation and drain
    @(negedge clk);
    sb_alloc = 1; sb_alloc_addr = 1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2 chk("t5_busy1", sb_busy[1], 1);
    chk("t5_alloc_ok0", sb_alloc_ok, 0);
    @(negedge clk);
    sb_alloc = 0;
    drive_req(0, 1, 8'h11, 0, 0); req_valid = 4'b0001;
    #2 chk("t5_alloc_ok_still0", sb_alloc_ok, 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    req_valid = 0;
    #2 chk("t5_busy1_last", sb_busy[1], 1);
    @(negedge clk);
    #2 chk("t5_busy1_clear", sb_busy[1], 0);

    // same-cycle alloc + commit
    @(negedge clk);
    sb_alloc = 1; sb_alloc_addr = 3;
    drive_req(0, 3, 8'h55, 0, 0); req_valid = 4'b0001;
    @(negedge clk);
    req_valid = 0;
    #2 chk("t6_wr_en", wr_en, 1);
    chk("t6_wr_addr", wr_addr, 3);
    chk("t6_busy3", sb_busy[3], 1);
    @(negedge clk);
    sb_alloc = 0; req_valid = 4'b0001;
    #2 chk("t6_busy3_kept", sb_busy[3], 1);
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    #2 chk("t6_busy3_clear", sb_busy[3], 0);

    // randomized traffic, requesters hold payload until granted
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < 4; i++) begin
        if (!(req_valid[i] && !m_last_grant[i])) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          drive_req(i, $urandom_range(0, 3), $urandom_range(0, 255),
                    1'($urandom_range(0, 1)), $urandom_range(0, 15));
        end
      end
      wr_hold       = ($urandom_range(0, 4) == 0);
      sb_alloc      = ($urandom_range(0, 2) == 0);
      sb_alloc_addr = 2'($urandom_range(0, 3));
    end
    @(negedge clk);
    clr_inputs(); rst = 0;
    repeat (3) @(negedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
